// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry produce a + b + cin
// one bit per clock, LSB first; the result word is published on a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] res_sr_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] res_next;

  // Single full-adder cell operating on the current LSBs.
  assign bit_sum   = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign bit_carry = (a_sr_reg[0] & b_sr_reg[0]) | ((a_sr_reg[0] ^ b_sr_reg[0]) & carry_reg);
  assign res_next  = {bit_sum, res_sr_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      res_sr_reg <= '0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
          res_sr_reg <= res_next;
          carry_reg  <= bit_carry;
          cnt_reg    <= cnt_reg + 1'b1;
          // Outputs change only here, so sum/cout are never seen half-built.
          if (cnt_reg == LAST_BIT) begin
            sum_reg   <= res_next;
            cout_reg  <= bit_carry;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=5, using a
// queue of expected {cout,sum} words pushed at acceptance and popped on done.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start5 = 1'b0;
  logic [4:0] a5 = '0;
  logic [4:0] b5 = '0;
  logic       cin5 = 1'b0;
  logic       busy5, done5, cout5;
  logic [4:0] sum5;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .a(a5), .b(b5), .cin(cin5),
    .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] res8();
    return {cout8, sum8};
  endfunction

  function automatic logic [8:0] res5();
    return {3'b000, cout5, sum5};
  endfunction

  task automatic wait_done(input bit w5, output int cyc);
    cyc = 0;
    while (!(w5 ? done5 : done8) && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic pop_check(input string tag, input logic [8:0] obs);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  // One complete operation: pulse start, wait for done, check latency, result, pulse width.
  task automatic run_op(input bit w5, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input string tag);
    int cyc;
    logic [8:0] e;
    if (w5) begin
      e = 9'(av[4:0]) + 9'(bv[4:0]) + 9'(ci);
      a5 = av[4:0]; b5 = bv[4:0]; cin5 = ci; start5 = 1'b1;
    end else begin
      e = 9'(av) + 9'(bv) + 9'(ci);
      a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    end
    exp_q.push_back(e);
    step();
    start5 = 1'b0;
    start8 = 1'b0;
    wait_done(w5, cyc);
    check({tag, "_latency"}, 32'(cyc), w5 ? 32'd5 : 32'd8);
    pop_check({tag, "_sum"}, w5 ? res5() : res8());
    step();
    check({tag, "_done_width"}, 32'(w5 ? done5 : done8), 32'd0);
  endtask

  initial begin
    int cyc;
    int done_cnt;

    step();
    step();
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum", 32'(sum8), 32'd0);
    check("reset_cout", 32'(cout8), 32'd0);
    check("reset_sum5", 32'(res5()), 32'd0);
    rst_n = 1'b1;
    step();

    // 0x35 + 0x4A with cycle-exact busy/done tracking.
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(9'h07F);
    step();
    start8 = 1'b0;
    check("t1_busy_e0", 32'(busy8), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("t1_busy_e%0d", i), 32'(busy8), 32'd1);
      check($sformatf("t1_done_e%0d", i), 32'(done8), 32'd0);
    end
    step();
    check("t1_done_e8", 32'(done8), 32'd1);
    check("t1_busy_e8", 32'(busy8), 32'd0);
    pop_check("t1_sum", res8());
    step();
    check("t1_done_e9", 32'(done8), 32'd0);
    step();
    step();
    check("t1_hold", 32'(res8()), 32'h07F);

    run_op(1'b0, 8'hFF, 8'h01, 1'b0, "t2_ff_01");
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1, "t2_ff_ff_c");

    // start held high; operands changed during RUN must not leak in.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    exp_q.push_back(9'h030);
    step();
    a8 = 8'h01; b8 = 8'h02;
    wait_done(1'b0, cyc);
    check("t3_latency1", 32'(cyc), 32'd8);
    pop_check("t3_sum1", res8());
    step();
    check("t3_busy_e9", 32'(busy8), 32'd0);
    step();
    check("t3_busy_e10", 32'(busy8), 32'd1);
    exp_q.push_back(9'h003);
    start8 = 1'b0;
    a8 = 8'h77; b8 = 8'h66;
    wait_done(1'b0, cyc);
    check("t3_latency2", 32'(cyc), 32'd8);
    pop_check("t3_sum2", res8());
    step();

    // start during RUN and during DONE is ignored.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    exp_q.push_back(9'h047);
    step();
    start8 = 1'b0;
    step();
    step();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      start8 = 1'b0;
      if (done8) begin
        done_cnt++;
        if (done_cnt == 1) pop_check("t4_sum", res8());
        start8 = 1'b1;
      end
    end
    check("t4_done_count", 32'(done_cnt), 32'd1);
    check("t4_idle_busy", 32'(busy8), 32'd0);
    check("t4_hold", 32'(res8()), 32'h047);

    // Reset in the middle of a RUN aborts it silently.
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_done", 32'(done8), 32'd0);
    check("t5_sum", 32'(sum8), 32'd0);
    check("t5_cout", 32'(cout8), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) done_cnt++;
    end
    check("t5_no_done", 32'(done_cnt), 32'd0);
    run_op(1'b0, 8'h01, 8'h01, 1'b0, "t5_fresh");

    for (int i = 0; i < 1000; i++) begin
      run_op(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), $sformatf("rnd8_%0d", i));
    end
    for (int i = 0; i < 1000; i++) begin
      run_op(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), $sformatf("rnd5_%0d", i));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: computes sum = a + b + cin one bit per clock, LSB first, using a single full-adder cell and a registered carry.
- It is the add-direction counterpart of the team's full-subtractor cell. It is used where area matters more than latency, and as the adder stage in the lab's arithmetic datapath.
- Operands are loaded in parallel on a start handshake. The result is returned in parallel with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2)

Ports:
- clk, input, 1, system clock; all state updates on the rising edge
- rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk
- start, input, 1, request a new addition; honoured only in IDLE
- a, input, WIDTH, augend; sampled only on the accepting edge
- b, input, WIDTH, addend; sampled only on the accepting edge
- cin, input, 1, carry-in; sampled only on the accepting edge
- busy, output, 1, high while bits are being processed (RUN)
- done, output, 1, one-cycle pulse: sum/cout valid and new
- sum, output, WIDTH, registered result
- cout, output, 1, registered carry-out of bit WIDTH-1

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers/count/carry=0. Reset overrides start and any operation in progress. An aborted operation produces no done pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: load A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, state<=RUN, busy<=1.
  - sum/cout keep their previous values until the final RUN edge.
- RUN, each edge:
  - s = A_sr[0]^B_sr[0]^carry.
  - carry <= (A_sr[0]&B_sr[0]) | ((A_sr[0]^B_sr[0])&carry).
  - Shift A_sr and B_sr right by 1; shift s into an internal result register from the MSB side.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: state<=DONE, busy<=0, done<=1, sum<=final result word, cout<=final carry.
  - start is ignored in RUN; a/b/cin changes are ignored.
- DONE: one cycle only. Next edge: done<=0, state<=IDLE. start is ignored in DONE.
- Latency:
  - start sampled at edge E0; RUN covers edges E1..EWIDTH.
  - done=1 and sum/cout valid after EWIDTH, i.e. WIDTH cycles after acceptance.
  - done drops after EWIDTH+1.
  - Earliest next acceptance is EWIDTH+2, so with start held high the throughput is one operation per WIDTH+2 cycles.
- Arithmetic: modulo 2^WIDTH in sum; the overflow bit goes to cout. The result equals {cout,sum} = a+b+cin exactly.
- sum/cout hold their value indefinitely after done until the next operation completes. They are never partially updated during RUN.
- cnt is wide enough for WIDTH-1 (clog2(WIDTH) bits) and never wraps within an operation.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start pulse at E0 -> busy=1 for E1..E7; done=1 only after E8; sum=0x7F, cout=0; done=0 after E9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full carry ripple over all bits).
- start held high continuously with a=0x10, b=0x20, then a/b changed to 0x01/0x02 during RUN -> first done reports 0x30. The second operation is accepted exactly 10 cycles after the first and reports 0x03.
- start pulsed again at E3 with a=0xAA, b=0x55 during RUN, and at E8 during DONE -> both ignored; exactly one done pulse with the original result; the FSM returns to IDLE.
- rst_n=0 at E4 of a RUN on 0x35+0x4A -> busy=0, done=0, sum=0x00, cout=0 after that edge; no done pulse follows. A fresh start of 0x01+0x01 then gives sum=0x02 after 8 cycles.
- Sweep of 1000 random a/b/cin at WIDTH=8 and at WIDTH=5 -> {cout,sum} == a+b+cin every time; done width is always exactly 1 cycle.
